// File: rtl/xfer_pkg.sv
// -----------------------------------------------------------------------------
// xfer_pkg
// Shared definitions for the paged transfer queue (xfer_page_queue and its
// per-direction ring, xfer_page_ring).
//
// Contents:
//   ptr_w / idx_w / cnt_w : width helpers. Every module derives its local
//                           PTR_W, IDX_W and CNT_W from its own PAGE_COUNT and
//                           PAGE_WORDS parameters using these functions.
//   DESC_CNT_W            : width of the stored per-page word count. It holds
//                           counts up to 2**(DESC_CNT_W-1), so PAGE_WORDS may be
//                           at most 65536.
//   page_desc_t           : per-page descriptor. It exists only when
//                           XFER_PARTIAL_COMMIT_EN is defined, because only
//                           partial commits need to remember a page's length.
// -----------------------------------------------------------------------------
package xfer_pkg;

    localparam int DESC_CNT_W = 17;

    // Page pointer width: $clog2(PAGE_COUNT).
    function automatic int ptr_w(input int page_count);
        return $clog2(page_count);
    endfunction

    // Word index width within a page: $clog2(PAGE_WORDS).
    function automatic int idx_w(input int page_words);
        return $clog2(page_words);
    endfunction

    // Occupancy count width: PTR_W + 1, so the count can reach PAGE_COUNT.
    function automatic int cnt_w(input int page_count);
        return $clog2(page_count) + 1;
    endfunction

`ifdef XFER_PARTIAL_COMMIT_EN
    // Number of valid words in a committed page (1..PAGE_WORDS).
    typedef struct packed {
        logic [DESC_CNT_W-1:0] words;
    } page_desc_t;
`endif

endpackage

// File: rtl/xfer_page_ring.sv
// -----------------------------------------------------------------------------
// xfer_page_ring
// One direction of the paged transfer queue: a ring of PAGE_COUNT pages of
// PAGE_WORDS words each.
//   - The writer fills the head page. A page is committed once it is full or,
//     with XFER_PARTIAL_COMMIT_EN, when an early commit is requested.
//   - The reader drains the tail page word by word. Popping the final stored
//     word of the page releases it.
//   - full_pages counts committed, not-yet-released pages. It is a single
//     register, so a commit and a release on the same edge cancel exactly.
//
// Optional feature: XFER_PARTIAL_COMMIT_EN. When this macro is defined, a page
// may be committed early with `commit`, and its word count is kept in a
// descriptor array. When it is undefined, `commit` is ignored.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   wr_valid/wr_data    writer word stream; wr_ready is the handshake output
//   commit              early commit of the partial head page (macro only)
//   rd_en               reader pop request
//   rd_data/rd_valid    registered read return, one cycle after rd_en
//   rd_last             the returned word is the final word of its page
//   avail               at least one committed page exists
//   full_pages          committed page count (0..PAGE_COUNT)
//   err_ovf / err_unf   sticky write-while-full / pop-while-empty flags
// -----------------------------------------------------------------------------
module xfer_page_ring
    import xfer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PAGE_WORDS = 1024,
    parameter int PAGE_COUNT = 4,
    localparam int CNT_W = cnt_w(PAGE_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  commit,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  avail,
    output logic [CNT_W-1:0]      full_pages,
    output logic                  err_ovf,
    output logic                  err_unf
);

    localparam int PTR_W  = ptr_w(PAGE_COUNT);
    localparam int IDX_W  = idx_w(PAGE_WORDS);
    localparam int ADDR_W = PTR_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAGE_WORDS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PAGE_COUNT);

    logic [DATA_WIDTH-1:0] mem [0:PAGE_COUNT*PAGE_WORDS-1];

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic [CNT_W-1:0]      full_q, full_d;
    logic                  run_q, run_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  rd_last_q, rd_last_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_unf_q, err_unf_d;

    logic              wr_fire;
    logic              rd_fire;
    logic              commit_fire;
    logic              release_fire;
    logic              rd_page_end;
    logic              full_commit;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;

    // run_q keeps wr_ready low while reset is asserted and for the first
    // cycle after it, so that every handshake output starts from 0.
    assign wr_ready = run_q && (full_q != FULL_CNT);
    assign avail    = (full_q != '0);

    assign wr_fire  = wr_valid && wr_ready;
    assign rd_fire  = rd_en && avail;
    assign wr_addr  = {head_q, wr_idx_q};
    assign rd_addr  = {tail_q, rd_idx_q};

    assign full_commit = wr_fire && (wr_idx_q == LAST_IDX);

`ifdef XFER_PARTIAL_COMMIT_EN
    page_desc_t            desc_mem [0:PAGE_COUNT-1];
    page_desc_t            tail_desc;
    logic [DESC_CNT_W-1:0] commit_words;

    // An early commit needs at least one word in the page, counting a word
    // accepted on the same edge. It also needs a free page; a non-empty head
    // page implies one, and an empty page with a same-edge word is covered by
    // wr_fire.
    assign commit_fire = full_commit ||
                         (commit && wr_ready && (wr_fire || (wr_idx_q != '0)));

    always_comb begin
        commit_words = DESC_CNT_W'(wr_idx_q);
        if (wr_fire) begin
            commit_words = DESC_CNT_W'(wr_idx_q) + DESC_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (commit_fire) begin
            desc_mem[head_q] <= '{words: commit_words};
        end
    end

    assign tail_desc   = desc_mem[tail_q];
    assign rd_page_end = ((DESC_CNT_W'(rd_idx_q) + DESC_CNT_W'(1)) == tail_desc.words);
`else
    logic unused_commit;

    assign unused_commit = commit;
    assign commit_fire   = full_commit;
    assign rd_page_end   = (rd_idx_q == LAST_IDX);
`endif

    assign release_fire = rd_fire && rd_page_end;

    // The page RAM has no reset. A page is never read and written on the same
    // edge, because the reader only ever touches committed pages.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        full_d     = full_q;
        run_d      = 1'b1;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_fire;
        rd_last_d  = release_fire;
        err_ovf_d  = err_ovf_q || (wr_valid && !wr_ready);
        err_unf_d  = err_unf_q || (rd_en && !avail);

        if (wr_fire) begin
            wr_idx_d = wr_idx_q + 1'b1;
        end
        if (commit_fire) begin
            head_d   = head_q + 1'b1;
            wr_idx_d = '0;
        end

        if (rd_fire) begin
            rd_data_d = mem[rd_addr];
            rd_idx_d  = rd_idx_q + 1'b1;
        end
        if (release_fire) begin
            tail_d   = tail_q + 1'b1;
            rd_idx_d = '0;
        end

        case ({commit_fire, release_fire})
            2'b10:   full_d = full_q + 1'b1;
            2'b01:   full_d = full_q - 1'b1;
            default: full_d = full_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            full_q     <= '0;
            run_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            err_unf_q  <= 1'b0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            full_q     <= full_d;
            run_q      <= run_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            err_ovf_q  <= err_ovf_d;
            err_unf_q  <= err_unf_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign full_pages = full_q;
    assign err_ovf    = err_ovf_q;
    assign err_unf    = err_unf_q;

endmodule

// File: rtl/xfer_page_queue.sv
// -----------------------------------------------------------------------------
// xfer_page_queue
// A paged, bidirectional word queue between the host port and the bottom-half
// (memory-side) engine. It contains two xfer_page_ring instances:
//   RX : the host writes and the bottom half reads. The status port reports
//        free pages.
//   TX : the bottom half writes and the host reads. The status port reports
//        full pages.
//
// Optional feature: XFER_PARTIAL_COMMIT_EN. It is handled inside
// xfer_page_ring. With the macro defined, h_commit closes a partial RX page;
// without it, h_commit is ignored.
//
// Ports:
//   clock_host, reset                 clock, asynchronous active-low reset
//   h_wr_valid/h_wr_data/h_wr_ready   host -> RX word stream
//   h_commit                          host closes the partial RX page
//   h_rd_req, h_rd_data/h_rd_valid    host pops TX; 1-cycle registered return
//   m_rx_avail                        a committed RX page exists
//   m_rx_rd_en, m_rx_data/m_rx_dvalid/m_rx_last
//                                     bottom half pops RX; last = page end
//   m_tx_wr_en/m_tx_data/m_tx_ready   bottom half -> TX word stream
//   rx_free_pages / tx_full_pages     occupancy status
//   err_ovf / err_unf                 sticky, OR of both directions
// -----------------------------------------------------------------------------
module xfer_page_queue
    import xfer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PAGE_WORDS = 1024,
    parameter int PAGE_COUNT = 4,
    localparam int CNT_W = cnt_w(PAGE_COUNT)
) (
    input  logic                  clock_host,
    input  logic                  reset,
    input  logic                  h_wr_valid,
    input  logic [DATA_WIDTH-1:0] h_wr_data,
    output logic                  h_wr_ready,
    input  logic                  h_commit,
    input  logic                  h_rd_req,
    output logic [DATA_WIDTH-1:0] h_rd_data,
    output logic                  h_rd_valid,
    output logic                  m_rx_avail,
    input  logic                  m_rx_rd_en,
    output logic [DATA_WIDTH-1:0] m_rx_data,
    output logic                  m_rx_dvalid,
    output logic                  m_rx_last,
    input  logic                  m_tx_wr_en,
    input  logic [DATA_WIDTH-1:0] m_tx_data,
    output logic                  m_tx_ready,
    output logic [CNT_W-1:0]      rx_free_pages,
    output logic [CNT_W-1:0]      tx_full_pages,
    output logic                  err_ovf,
    output logic                  err_unf
);

    localparam logic [CNT_W-1:0] PAGES = CNT_W'(PAGE_COUNT);

    logic [CNT_W-1:0] rx_full;
    logic             rx_ovf, rx_unf;
    logic             tx_ovf, tx_unf;
    logic             tx_last_unused;
    logic             tx_avail_unused;

    xfer_page_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .PAGE_WORDS (PAGE_WORDS),
        .PAGE_COUNT (PAGE_COUNT)
    ) u_rx (
        .clk        (clock_host),
        .rst_n      (reset),
        .wr_valid   (h_wr_valid),
        .wr_data    (h_wr_data),
        .wr_ready   (h_wr_ready),
        .commit     (h_commit),
        .rd_en      (m_rx_rd_en),
        .rd_data    (m_rx_data),
        .rd_valid   (m_rx_dvalid),
        .rd_last    (m_rx_last),
        .avail      (m_rx_avail),
        .full_pages (rx_full),
        .err_ovf    (rx_ovf),
        .err_unf    (rx_unf)
    );

    // TX pages always fill completely; the bottom half has no early commit.
    xfer_page_ring #(
        .DATA_WIDTH (DATA_WIDTH),
        .PAGE_WORDS (PAGE_WORDS),
        .PAGE_COUNT (PAGE_COUNT)
    ) u_tx (
        .clk        (clock_host),
        .rst_n      (reset),
        .wr_valid   (m_tx_wr_en),
        .wr_data    (m_tx_data),
        .wr_ready   (m_tx_ready),
        .commit     (1'b0),
        .rd_en      (h_rd_req),
        .rd_data    (h_rd_data),
        .rd_valid   (h_rd_valid),
        .rd_last    (tx_last_unused),
        .avail      (tx_avail_unused),
        .full_pages (tx_full_pages),
        .err_ovf    (tx_ovf),
        .err_unf    (tx_unf)
    );

    // The RX status reports free pages, so it is the complement of the ring's
    // committed count.
    assign rx_free_pages = PAGES - rx_full;
    assign err_ovf       = rx_ovf | tx_ovf;
    assign err_unf       = rx_unf | tx_unf;

endmodule

// File: tb/tb_xfer_page_queue.sv
// -----------------------------------------------------------------------------
// tb_xfer_page_queue
// Directed bench for xfer_page_queue with PAGE_WORDS=4 and PAGE_COUNT=2.
// Every pop request pushes its expected word into a queue. The monitor
// compares that queue against the returned data whenever a valid strobe
// appears. Status and error flags are checked directly after the relevant
// edges.
// -----------------------------------------------------------------------------
module tb_xfer_page_queue;

    localparam int DW = 32;
    localparam int PW = 4;
    localparam int PC = 2;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          h_wr_valid = 1'b0;
    logic [DW-1:0] h_wr_data = '0;
    logic          h_wr_ready;
    logic          h_commit = 1'b0;
    logic          h_rd_req = 1'b0;
    logic [DW-1:0] h_rd_data;
    logic          h_rd_valid;
    logic          m_rx_avail;
    logic          m_rx_rd_en = 1'b0;
    logic [DW-1:0] m_rx_data;
    logic          m_rx_dvalid;
    logic          m_rx_last;
    logic          m_tx_wr_en = 1'b0;
    logic [DW-1:0] m_tx_data = '0;
    logic          m_tx_ready;
    logic [CW-1:0] rx_free_pages;
    logic [CW-1:0] tx_full_pages;
    logic          err_ovf;
    logic          err_unf;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } rx_exp_t;

    rx_exp_t       rx_q[$];
    logic [DW-1:0] tx_q[$];
    int            n_checks = 0;
    int            n_fail = 0;

    xfer_page_queue #(
        .DATA_WIDTH (DW),
        .PAGE_WORDS (PW),
        .PAGE_COUNT (PC)
    ) dut (
        .clock_host    (clk),
        .reset         (rst_n),
        .h_wr_valid    (h_wr_valid),
        .h_wr_data     (h_wr_data),
        .h_wr_ready    (h_wr_ready),
        .h_commit      (h_commit),
        .h_rd_req      (h_rd_req),
        .h_rd_data     (h_rd_data),
        .h_rd_valid    (h_rd_valid),
        .m_rx_avail    (m_rx_avail),
        .m_rx_rd_en    (m_rx_rd_en),
        .m_rx_data     (m_rx_data),
        .m_rx_dvalid   (m_rx_dvalid),
        .m_rx_last     (m_rx_last),
        .m_tx_wr_en    (m_tx_wr_en),
        .m_tx_data     (m_tx_data),
        .m_tx_ready    (m_tx_ready),
        .rx_free_pages (rx_free_pages),
        .tx_full_pages (tx_full_pages),
        .err_ovf       (err_ovf),
        .err_unf       (err_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor. It samples on the falling edge, away from the
    // edge where the registered outputs update.
    always @(negedge clk) begin
        rx_exp_t       e;
        logic [DW-1:0] t;
        if (rst_n) begin
            if (m_rx_dvalid) begin
                if (rx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got data 0x%0h, expected no word", m_rx_data);
                end else begin
                    e = rx_q.pop_front();
                    check("rx_data", m_rx_data, e.data);
                    check("rx_last", 32'(m_rx_last), 32'(e.last));
                end
            end
            if (h_rd_valid) begin
                if (tx_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL tx_unexpected: got data 0x%0h, expected no word", h_rd_data);
                end else begin
                    t = tx_q.pop_front();
                    check("tx_data", h_rd_data, t);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [DW-1:0] d, input logic cmt);
        h_wr_valid = 1'b1;
        h_wr_data  = d;
        h_commit   = cmt;
        tick();
        h_wr_valid = 1'b0;
        h_commit   = 1'b0;
    endtask

    task automatic host_commit();
        h_commit = 1'b1;
        tick();
        h_commit = 1'b0;
    endtask

    task automatic pop_rx(input logic [DW-1:0] d, input logic last);
        m_rx_rd_en = 1'b1;
        rx_q.push_back('{data: d, last: last});
        tick();
        m_rx_rd_en = 1'b0;
    endtask

    initial begin
        // ---------------- reset values ----------------
        tick();
        check("rst_wr_ready_in_reset", 32'(h_wr_ready), 0);
        check("rst_rx_free_in_reset", 32'(rx_free_pages), 2);
        rst_n = 1'b1;
        tick();
        tick();
        check("rst_rx_free", 32'(rx_free_pages), 2);
        check("rst_tx_full", 32'(tx_full_pages), 0);
        check("rst_h_wr_ready", 32'(h_wr_ready), 1);
        check("rst_m_tx_ready", 32'(m_tx_ready), 1);
        check("rst_valids", 32'({h_rd_valid, m_rx_dvalid, m_rx_last, m_rx_avail}), 0);
        check("rst_errs", 32'({err_ovf, err_unf}), 0);
        check("rst_data", h_rd_data | m_rx_data, 0);

        // ---------------- fill RX, overflow, drain ----------------
        for (int k = 0; k < 8; k++) begin
            host_write(32'h10 + k, 1'b0);
            if (k == 3) check("rx_free_after_page0", 32'(rx_free_pages), 1);
        end
        check("fill_h_wr_ready", 32'(h_wr_ready), 0);
        check("fill_rx_free", 32'(rx_free_pages), 0);
        check("fill_rx_avail", 32'(m_rx_avail), 1);
        host_write(32'h18, 1'b0);
        check("ovf_flag", 32'(err_ovf), 1);
        check("ovf_rx_free", 32'(rx_free_pages), 0);
        for (int k = 0; k < 8; k++) begin
            pop_rx(32'h10 + k, (k == 3) || (k == 7));
        end
        check("drain_rx_free", 32'(rx_free_pages), 2);
        check("drain_h_wr_ready", 32'(h_wr_ready), 1);

        // ---------------- commit and release on the same edge ----------------
        for (int k = 0; k < 7; k++) host_write(32'h20 + k, 1'b0);
        check("pre_window_rx_free", 32'(rx_free_pages), 1);
        for (int k = 0; k < 4; k++) begin
            m_rx_rd_en = 1'b1;
            rx_q.push_back('{data: 32'h20 + k, last: (k == 3)});
            m_tx_wr_en = 1'b1;
            m_tx_data  = 32'h30 + k;
            if (k == 3) begin
                h_wr_valid = 1'b1;
                h_wr_data  = 32'h27;
            end
            tick();
            check("window_rx_free", 32'(rx_free_pages), 1);
        end
        m_rx_rd_en = 1'b0;
        m_tx_wr_en = 1'b0;
        h_wr_valid = 1'b0;
        check("window_tx_full", 32'(tx_full_pages), 1);
        check("window_m_tx_ready", 32'(m_tx_ready), 1);
        check("window_rx_avail", 32'(m_rx_avail), 1);

        // ---------------- all four streams at one word per cycle ----------------
        for (int k = 0; k < 4; k++) begin
            h_rd_req   = 1'b1;
            tx_q.push_back(32'h30 + k);
            m_rx_rd_en = 1'b1;
            rx_q.push_back('{data: 32'h24 + k, last: (k == 3)});
            m_tx_wr_en = 1'b1;
            m_tx_data  = 32'h38 + k;
            h_wr_valid = 1'b1;
            h_wr_data  = 32'h28 + k;
            tick();
            check("stream4_rx_free", 32'(rx_free_pages), 1);
            check("stream4_tx_full", 32'(tx_full_pages), 1);
        end
        m_tx_wr_en = 1'b0;
        h_wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            h_rd_req   = 1'b1;
            tx_q.push_back(32'h38 + k);
            m_rx_rd_en = 1'b1;
            rx_q.push_back('{data: 32'h28 + k, last: (k == 3)});
            tick();
        end
        h_rd_req   = 1'b0;
        m_rx_rd_en = 1'b0;
        check("stream4_end_rx_free", 32'(rx_free_pages), 2);
        check("stream4_end_tx_full", 32'(tx_full_pages), 0);

        // ---------------- underflow on TX ----------------
        h_rd_req = 1'b1;
        tick();
        h_rd_req = 1'b0;
        check("unf_h_rd_valid", 32'(h_rd_valid), 0);
        check("unf_flag", 32'(err_unf), 1);
        check("ovf_sticky", 32'(err_ovf), 1);
        tick();

        // ---------------- reset mid-page discards the partial page ----------------
        host_write(32'h40, 1'b0);
        host_write(32'h41, 1'b0);
        rst_n = 1'b0;
        tick();
        check("midrst_rx_free", 32'(rx_free_pages), 2);
        check("midrst_rx_avail", 32'(m_rx_avail), 0);
        check("midrst_errs", 32'({err_ovf, err_unf}), 0);
        rst_n = 1'b1;
        tick();
        tick();
        check("postrst_rx_free", 32'(rx_free_pages), 2);
        check("postrst_rx_avail", 32'(m_rx_avail), 0);
        for (int k = 0; k < 3; k++) host_write(32'h42 + k, 1'b0);
        check("postrst_no_early_commit", 32'(rx_free_pages), 2);
        host_write(32'h45, 1'b0);
        check("postrst_commit", 32'(rx_free_pages), 1);
        for (int k = 0; k < 4; k++) pop_rx(32'h42 + k, (k == 3));
        check("postrst_drain", 32'(rx_free_pages), 2);

        // ---------------- partial commit ----------------
        for (int k = 0; k < 3; k++) host_write(32'h50 + k, 1'b0);
        host_commit();
`ifdef XFER_PARTIAL_COMMIT_EN
        check("pc_rx_free", 32'(rx_free_pages), 1);
        check("pc_rx_avail", 32'(m_rx_avail), 1);
        for (int k = 0; k < 3; k++) pop_rx(32'h50 + k, (k == 2));
        check("pc_drain", 32'(rx_free_pages), 2);
        host_write(32'h60, 1'b0);
        host_write(32'h61, 1'b1);
        check("pc_with_word_rx_free", 32'(rx_free_pages), 1);
        pop_rx(32'h60, 1'b0);
        pop_rx(32'h61, 1'b1);
        host_commit();
        check("pc_empty_ignored", 32'(rx_free_pages), 2);
`else
        check("nopc_rx_free", 32'(rx_free_pages), 2);
        check("nopc_rx_avail", 32'(m_rx_avail), 0);
        host_write(32'h53, 1'b0);
        check("nopc_full_commit", 32'(rx_free_pages), 1);
        for (int k = 0; k < 4; k++) pop_rx(32'h50 + k, (k == 3));
        check("nopc_drain", 32'(rx_free_pages), 2);
`endif

        tick();
        tick();
        check("sb_rx_drained", 32'(rx_q.size()), 0);
        check("sb_tx_drained", 32'(tx_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
